// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST classifier datapath: image geometry and
// the pixel feeder state encoding.
package mnist_pkg;

  localparam int PIX_W      = 8;
  localparam int IMG_PIXELS = 784;
  localparam int IMG_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/pixel_feeder_if.sv
// Image RAM read port plus input-buffer write port of the pixel feeder.
// The master side is the feeder; the slave side is the RAM/buffer pair.
interface pixel_feeder_if
  import mnist_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int ADDR_W = IMG_ADDR_W
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_ready;
  logic              out_wr_en;
  logic [DATA_W-1:0] out_data;

  modport master (
    output mem_rd_en, mem_addr, out_wr_en, out_data,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_wr_en, out_data,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO absorbing RAM read data while the downstream stalls.
// Head is combinational from storage; flush empties it in one cycle.
module skid_fifo2
  import mnist_pkg::*;
#(
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [1:0][DATA_W-1:0] mem_q, mem_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pixel_feeder.sv
// Streams one image from the synchronous image RAM into the classifier input
// buffer in address order, with credit-limited reads and downstream backpressure.
module pixel_feeder
  import mnist_pkg::*;
#(
  parameter int DATA_W     = PIX_W,
  parameter int NUM_PIXELS = IMG_PIXELS,
  parameter int ADDR_W     = IMG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  pixel_feeder_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pix_count
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              inflight_q, inflight_d;

  logic              run;
  logic              issue;
  logic              push;
  logic              pop;
  logic              flush;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [2:0]        credit;

  assign run = (state_q == RUN);
  assign pop = run && (fifo_count != 2'd0) && bus.out_ready;

  // Entries that will still occupy the FIFO next cycle: at most one more read
  // may be outstanding, so the 2-entry FIFO can never overflow.
  assign credit = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = run && (rd_addr_q < LAST_CNT) && (credit <= 3'd1);
  assign push   = run && inflight_q && !abort;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    pix_cnt_d  = pix_cnt_q;
    inflight_d = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = RUN;
          rd_addr_d = '0;
          pix_cnt_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          rd_addr_d = '0;
          pix_cnt_d = '0;
          flush     = 1'b1;
        end else begin
          inflight_d = issue;
          if (issue) begin
            rd_addr_d = rd_addr_q + ONE;
          end
          if (pop && (pix_cnt_q < LAST_CNT)) begin
            pix_cnt_d = pix_cnt_q + ONE;
          end
          if (pix_cnt_d == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      pix_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      pix_cnt_q  <= pix_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.mem_rdata),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // The address bus only carries a value while a read is actually issued.
  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = issue ? rd_addr_q : '0;
  assign bus.out_wr_en = pop;
  assign bus.out_data  = fifo_head;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pix_count = pix_cnt_q;

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed bench for pixel_feeder: RAM model, write monitor and immediate
// assertions over streaming, backpressure, abort, reset and restart cases.
module tb_pixel_feeder;
  import mnist_pkg::*;

  localparam int N = IMG_PIXELS;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic [IMG_ADDR_W-1:0] pix_count;

  pixel_feeder_if #(.DATA_W(PIX_W), .ADDR_W(IMG_ADDR_W)) bus ();

  pixel_feeder #(
    .DATA_W     (PIX_W),
    .NUM_PIXELS (N),
    .ADDR_W     (IMG_ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count)
  );

  always #5 clk = ~clk;

  logic [7:0] seed;

  function automatic logic [7:0] ram_val(input int a);
    return 8'(a) + seed;
  endfunction

  // Synchronous image RAM: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_rd_en ? ram_val(int'(bus.mem_addr)) : 8'hA5;
  end

  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;
  int   e0 = 0;
  int   rdy_mode = 0;
  logic rdy_manual = 1'b1;

  int   wr_total, rd_issued, bad_data, bad_addr, viol, done_cnt;
  int   first_wr_edge, first_rd_edge, done_edge, done_pix;
  int   stall_bad, stall_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic reset_mon();
    wr_total = 0; rd_issued = 0; bad_data = 0; bad_addr = 0; viol = 0;
    done_cnt = 0; first_wr_edge = -1; first_rd_edge = -1; done_edge = -1;
    done_pix = -1;
  endtask

  // One clock: apply out_ready shortly after the edge, then observe the cycle.
  task automatic cyc();
    @(posedge clk);
    edge_n++;
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = rdy_manual;
    endcase
    #1;
    if (bus.mem_rd_en) begin
      if (first_rd_edge < 0) first_rd_edge = edge_n;
      if (bus.mem_addr !== IMG_ADDR_W'(rd_issued)) bad_addr++;
      if (rd_issued - wr_total - (bus.out_wr_en ? 1 : 0) > 1) viol++;
      rd_issued++;
    end
    if (bus.out_wr_en) begin
      if (first_wr_edge < 0) first_wr_edge = edge_n;
      if (!bus.out_ready) bad_data++;
      if (bus.out_data !== ram_val(wr_total)) bad_data++;
      wr_total++;
    end
    if (done) begin
      done_cnt++;
      done_edge = edge_n;
      done_pix  = int'(pix_count);
    end
  endtask

  task automatic begin_xfer();
    reset_mon();
    start = 1'b1;
    cyc();
    e0 = edge_n;
    start = 1'b0;
  endtask

  task automatic run_to_writes(input int n, input int budget);
    for (int i = 0; i < budget && wr_total < n; i++) cyc();
    chk("reach_writes", wr_total, n);
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cyc();
    repeat (4) cyc();
  endtask

  task automatic finish_checks(input string tag, input bit timing);
    chk($sformatf("%s.done_cnt", tag), done_cnt, 1);
    chk($sformatf("%s.writes", tag), wr_total, N);
    chk($sformatf("%s.reads", tag), rd_issued, N);
    chk($sformatf("%s.data_order", tag), bad_data, 0);
    chk($sformatf("%s.addr_order", tag), bad_addr, 0);
    chk($sformatf("%s.credit", tag), viol, 0);
    chk($sformatf("%s.done_pix", tag), done_pix, N);
    chk($sformatf("%s.busy_after", tag), busy, 0);
    if (timing) begin
      chk($sformatf("%s.first_rd_cycle", tag), first_rd_edge - e0 + 1, 1);
      chk($sformatf("%s.first_wr_cycle", tag), first_wr_edge - e0 + 1, 3);
      chk($sformatf("%s.done_cycle", tag), done_edge - e0 + 1, 787);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk($sformatf("%s.mem_rd_en", tag), bus.mem_rd_en, 0);
    chk($sformatf("%s.mem_addr", tag), bus.mem_addr, 0);
    chk($sformatf("%s.out_wr_en", tag), bus.out_wr_en, 0);
    chk($sformatf("%s.out_data", tag), bus.out_data, 0);
    chk($sformatf("%s.busy", tag), busy, 0);
    chk($sformatf("%s.done", tag), done, 0);
    chk($sformatf("%s.pix_count", tag), pix_count, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.out_ready = 1'b1; seed = 8'h00;
    reset_mon();
    #2;
    chk_idle("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full image, ready always high, RAM[i] = i[7:0]
    seed = 8'h00; rdy_mode = 0;
    begin_xfer();
    chk("stream.busy", busy, 1);
    run_until_done(2000);
    finish_checks("stream", 1'b1);

    // Ready toggling every cycle
    seed = 8'h37; rdy_mode = 1;
    begin_xfer();
    run_until_done(4000);
    finish_checks("toggle", 1'b0);

    // 20-cycle stall at pixel 300
    seed = 8'h5C; rdy_mode = 0;
    begin_xfer();
    run_to_writes(300, 1000);
    rdy_mode = 2; rdy_manual = 1'b0; stall_bad = 0; stall_rd = 0;
    repeat (20) begin
      cyc();
      if (bus.out_data !== ram_val(300)) stall_bad++;
      if (bus.out_wr_en) stall_bad++;
      if (bus.mem_rd_en) stall_rd++;
    end
    chk("stall.hold", stall_bad, 0);
    chk("stall.reads", stall_rd, 0);
    chk("stall.pix_count", pix_count, 300);
    rdy_mode = 0;
    run_until_done(2000);
    finish_checks("stall", 1'b0);

    // Abort at pixel 500, then a clean rewrite
    seed = 8'h91;
    begin_xfer();
    run_to_writes(500, 1000);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.pix_count", pix_count, 0);
    chk("abort.done", done, 0);
    repeat (6) cyc();
    chk("abort.no_done", done_cnt, 0);
    chk("abort.writes", wr_total, 500);
    seed = 8'h92;
    begin_xfer();
    run_until_done(2000);
    finish_checks("rewrite", 1'b0);

    // Async reset after 100 pixels, then restream from address 0
    seed = 8'h6B;
    begin_xfer();
    run_to_writes(100, 1000);
    #1 rst = 1'b1;
    #1;
    chk_idle("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    seed = 8'h6C;
    begin_xfer();
    run_until_done(2000);
    finish_checks("after_rst", 1'b1);

    // start+abort together in IDLE does nothing
    reset_mon();
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("start_abort.busy", busy, 0);
    repeat (4) cyc();
    chk("start_abort.reads", rd_issued, 0);
    chk("start_abort.done", done_cnt, 0);

    // start held while busy is ignored
    seed = 8'h22;
    begin_xfer();
    run_to_writes(50, 1000);
    start = 1'b1;
    repeat (10) cyc();
    start = 1'b0;
    run_until_done(2000);
    finish_checks("restart", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
